// File: rtl/pc_gen_ras_if.sv
// Fetch-PC request/response bundle between the predictor/execute side (master)
// and the next-PC generator (slave).
interface pc_gen_ras_if #(
    parameter int XLEN      = 32,
    parameter int TGT_W     = 16,
    parameter int RAS_DEPTH = 4
);
    logic                             stall;
    logic                             IM_stall;
    logic                             DM_stall;
    logic                             mispredict;
    logic [XLEN-1:0]                  correctTarget;
    logic                             predictTaken;
    logic [TGT_W-1:0]                 predictedTarget;
    logic                             isCall;
    logic                             isRet;
    logic [XLEN-1:0]                  pc;
    logic [$clog2(RAS_DEPTH+1)-1:0]   rasCount;
    logic                             pcMisaligned;

    modport master (
        output stall, IM_stall, DM_stall, mispredict, correctTarget,
               predictTaken, predictedTarget, isCall, isRet,
        input  pc, rasCount, pcMisaligned
    );

    modport slave (
        input  stall, IM_stall, DM_stall, mispredict, correctTarget,
               predictTaken, predictedTarget, isCall, isRet,
        output pc, rasCount, pcMisaligned
    );
endinterface

// File: rtl/pc_gen_ras.sv
// Fetch PC generator with a circular return-address stack.
// Optional macro PC_ALIGN_CHK_EN: force targets word-aligned and flag misaligned ones.
module pc_gen_ras #(
    parameter int              XLEN      = 32,
    parameter int              TGT_W     = 16,
    parameter int              RAS_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    pc_gen_ras_if.slave       bus
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0]  r_pc;
    logic [PTR_W-1:0] r_tp;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_ras [RAS_DEPTH];

    logic             w_advance;
    logic             w_cnt_nz;
    logic             w_ret_hit;
    logic             w_push;
    logic             w_pop;
    logic             w_swap;
    logic             w_wr_en;
    logic [PTR_W-1:0] w_wr_idx;
    logic [PTR_W-1:0] w_tp_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [XLEN-1:0]  w_pc_plus4;
    logic [XLEN-1:0]  w_btb_tgt;
    logic [XLEN-1:0]  w_ras_top;
    logic [XLEN-1:0]  w_target;
    logic [XLEN-1:0]  w_next_pc;

    assign w_advance  = ~(bus.stall | bus.IM_stall | bus.DM_stall);
    assign w_cnt_nz   = (r_cnt != '0);
    assign w_ret_hit  = bus.isRet & w_cnt_nz;
    // Call+return on an empty stack degenerates into a plain push.
    assign w_push     = bus.isCall & (~bus.isRet | ~w_cnt_nz);
    assign w_pop      = bus.isRet & ~bus.isCall & w_cnt_nz;
    assign w_swap     = bus.isRet & bus.isCall & w_cnt_nz;
    assign w_pc_plus4 = r_pc + XLEN'(4);
    assign w_btb_tgt  = XLEN'(bus.predictedTarget);
    assign w_ras_top  = r_ras[r_tp];

    always_comb begin
        w_target = w_pc_plus4;
        if (bus.mispredict)
            w_target = bus.correctTarget;
        else if (w_ret_hit)
            w_target = w_ras_top;
        else if (bus.predictTaken)
            w_target = w_btb_tgt;
    end

    always_comb begin
        w_tp_next  = r_tp;
        w_cnt_next = r_cnt;
        w_wr_en    = 1'b0;
        w_wr_idx   = r_tp;
        if (bus.mispredict) begin
            w_tp_next  = '0;
            w_cnt_next = '0;
        end else if (w_push) begin
            w_tp_next  = r_tp + 1'b1;
            w_wr_en    = 1'b1;
            w_wr_idx   = r_tp + 1'b1;
            w_cnt_next = (r_cnt == CNT_W'(RAS_DEPTH)) ? r_cnt : r_cnt + 1'b1;
        end else if (w_pop) begin
            w_tp_next  = r_tp - 1'b1;
            w_cnt_next = r_cnt - 1'b1;
        end else if (w_swap) begin
            w_wr_en    = 1'b1;
        end
    end

`ifdef PC_ALIGN_CHK_EN
    logic r_misaligned;
    logic w_src_seq;

    assign w_src_seq = ~(bus.mispredict | w_ret_hit | bus.predictTaken);
    assign w_next_pc = {w_target[XLEN-1:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_misaligned <= 1'b0;
        else if (w_advance)
            r_misaligned <= ~w_src_seq & (w_target[1:0] != 2'b00);
    end

    assign bus.pcMisaligned = r_misaligned;
`else
    assign w_next_pc        = w_target;
    assign bus.pcMisaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc  <= RESET_PC;
            r_tp  <= '0;
            r_cnt <= '0;
        end else if (w_advance) begin
            r_pc  <= w_next_pc;
            r_tp  <= w_tp_next;
            r_cnt <= w_cnt_next;
        end
    end

    generate
        for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_ras[gi] <= '0;
                else if (w_advance && w_wr_en && (w_wr_idx == PTR_W'(gi)))
                    r_ras[gi] <= w_pc_plus4;
            end
        end
    endgenerate

    assign bus.pc       = r_pc;
    assign bus.rasCount = r_cnt;
endmodule

// File: tb/tb_pc_gen_ras.sv
// Directed bench for pc_gen_ras: sequential fetch, BTB, redirect, RAS, stalls, reset, alignment.
module tb_pc_gen_ras;
    localparam int XLEN = 32;
    localparam int TGT_W = 16;
    localparam int RAS_DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    pc_gen_ras_if #(.XLEN(XLEN), .TGT_W(TGT_W), .RAS_DEPTH(RAS_DEPTH)) bus ();

    pc_gen_ras #(.XLEN(XLEN), .TGT_W(TGT_W), .RAS_DEPTH(RAS_DEPTH), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic idle();
        bus.stall = 0; bus.IM_stall = 0; bus.DM_stall = 0;
        bus.mispredict = 0; bus.correctTarget = '0;
        bus.predictTaken = 0; bus.predictedTarget = '0;
        bus.isCall = 0; bus.isRet = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        $display("cycle pc=%h rasCount=%0d pcMisaligned=%0b", bus.pc, bus.rasCount, bus.pcMisaligned);
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        #12;
        n_checks++; if (bus.pc !== 32'h0) $display("FAIL reset_pc actual=%h required=%h", bus.pc, 32'h0); else n_pass++;
        n_checks++; if (bus.rasCount !== 3'd0) $display("FAIL reset_cnt actual=%0d required=0", bus.rasCount); else n_pass++;
        n_checks++; if (bus.pcMisaligned !== 1'b0) $display("FAIL reset_mis actual=%0b required=0", bus.pcMisaligned); else n_pass++;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        exp_pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_pc = exp_pc + 32'h4;
            n_checks++; if (bus.pc !== exp_pc) $display("FAIL seq_pc%0d actual=%h required=%h", i, bus.pc, exp_pc); else n_pass++;
        end
        n_checks++; if (bus.rasCount !== 3'd0) $display("FAIL seq_cnt actual=%0d required=0", bus.rasCount); else n_pass++;
    endtask

    task automatic test_btb();
        // pc = 12 now; redirect back to 8 to take the BTB hit from there
        bus.mispredict = 1; bus.correctTarget = 32'h8;
        tick();
        idle();
        n_checks++; if (bus.pc !== 32'h8) $display("FAIL btb_setup actual=%h required=%h", bus.pc, 32'h8); else n_pass++;
        bus.predictTaken = 1; bus.predictedTarget = 16'h0100;
        tick();
        idle();
        n_checks++; if (bus.pc !== 32'h100) $display("FAIL btb_taken actual=%h required=%h", bus.pc, 32'h100); else n_pass++;
        bus.mispredict = 1; bus.correctTarget = 32'h8;
        tick();
        bus.correctTarget = 32'h2000; bus.predictTaken = 1; bus.predictedTarget = 16'h0100;
        tick();
        idle();
        n_checks++; if (bus.pc !== 32'h2000) $display("FAIL btb_vs_mispredict actual=%h required=%h", bus.pc, 32'h2000); else n_pass++;
    endtask

    task automatic test_call_ret();
        bus.mispredict = 1; bus.correctTarget = 32'h40;
        tick();
        idle();
        bus.isCall = 1; bus.predictTaken = 1; bus.predictedTarget = 16'h0200;
        tick();
        idle();
        n_checks++; if (bus.pc !== 32'h200) $display("FAIL call_pc actual=%h required=%h", bus.pc, 32'h200); else n_pass++;
        n_checks++; if (bus.rasCount !== 3'd1) $display("FAIL call_cnt actual=%0d required=1", bus.rasCount); else n_pass++;
        tick();
        n_checks++; if (bus.pc !== 32'h204) $display("FAIL call_seq actual=%h required=%h", bus.pc, 32'h204); else n_pass++;
        bus.isRet = 1;
        tick();
        idle();
        n_checks++; if (bus.pc !== 32'h44) $display("FAIL ret_pc actual=%h required=%h", bus.pc, 32'h44); else n_pass++;
        n_checks++; if (bus.rasCount !== 3'd0) $display("FAIL ret_cnt actual=%0d required=0", bus.rasCount); else n_pass++;
    endtask

    task automatic test_ras_overflow();
        logic [31:0] tgt [5];
        logic [2:0]  exp_cnt [5];
        logic [31:0] ret_pc [4];
        tgt = '{32'h20, 32'h30, 32'h40, 32'h50, 32'h1000};
        exp_cnt = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        ret_pc = '{32'h54, 32'h44, 32'h34, 32'h24};
        bus.mispredict = 1; bus.correctTarget = 32'h10;
        tick();
        idle();
        for (int i = 0; i < 5; i++) begin
            bus.isCall = 1; bus.predictTaken = 1; bus.predictedTarget = tgt[i][15:0];
            tick();
            idle();
            n_checks++; if (bus.pc !== tgt[i] || bus.rasCount !== exp_cnt[i])
                $display("FAIL ovf_call%0d actual=%h/%0d required=%h/%0d", i, bus.pc, bus.rasCount, tgt[i], exp_cnt[i]);
            else n_pass++;
        end
        for (int i = 0; i < 4; i++) begin
            bus.isRet = 1;
            tick();
            idle();
            n_checks++; if (bus.pc !== ret_pc[i] || bus.rasCount !== 3'(3 - i))
                $display("FAIL ovf_ret%0d actual=%h/%0d required=%h/%0d", i, bus.pc, bus.rasCount, ret_pc[i], 3 - i);
            else n_pass++;
        end
        bus.isRet = 1;
        tick();
        idle();
        n_checks++; if (bus.pc !== 32'h28 || bus.rasCount !== 3'd0)
            $display("FAIL ovf_ret_empty actual=%h/%0d required=%h/0", bus.pc, bus.rasCount, 32'h28);
        else n_pass++;
    endtask

    task automatic test_call_and_ret();
        bus.mispredict = 1; bus.correctTarget = 32'h100;
        tick();
        idle();
        bus.isCall = 1; bus.predictTaken = 1; bus.predictedTarget = 16'h0500;
        tick();
        idle();
        // simultaneous call+return: jump to old top (0x104), replace it with 0x504
        bus.isCall = 1; bus.isRet = 1;
        tick();
        idle();
        n_checks++; if (bus.pc !== 32'h104 || bus.rasCount !== 3'd1)
            $display("FAIL both_pc actual=%h/%0d required=%h/1", bus.pc, bus.rasCount, 32'h104);
        else n_pass++;
        bus.isRet = 1;
        tick();
        idle();
        n_checks++; if (bus.pc !== 32'h504 || bus.rasCount !== 3'd0)
            $display("FAIL both_ret actual=%h/%0d required=%h/0", bus.pc, bus.rasCount, 32'h504);
        else n_pass++;
        bus.isCall = 1; bus.isRet = 1;
        tick();
        idle();
        n_checks++; if (bus.pc !== 32'h508 || bus.rasCount !== 3'd1)
            $display("FAIL both_empty actual=%h/%0d required=%h/1", bus.pc, bus.rasCount, 32'h508);
        else n_pass++;
        bus.isRet = 1;
        tick();
        idle();
        n_checks++; if (bus.pc !== 32'h508 || bus.rasCount !== 3'd0)
            $display("FAIL both_empty_ret actual=%h/%0d required=%h/0", bus.pc, bus.rasCount, 32'h508);
        else n_pass++;
    endtask

    task automatic test_stall();
        bus.isCall = 1;
        tick();
        idle();
        n_checks++; if (bus.pc !== 32'h50C || bus.rasCount !== 3'd1)
            $display("FAIL stall_setup actual=%h/%0d required=%h/1", bus.pc, bus.rasCount, 32'h50C);
        else n_pass++;
        bus.mispredict = 1; bus.correctTarget = 32'h300;
        for (int i = 0; i < 3; i++) begin
            bus.stall = (i == 0); bus.IM_stall = (i == 1); bus.DM_stall = (i == 2);
            tick();
            n_checks++; if (bus.pc !== 32'h50C || bus.rasCount !== 3'd1)
                $display("FAIL stall_hold%0d actual=%h/%0d required=%h/1", i, bus.pc, bus.rasCount, 32'h50C);
            else n_pass++;
        end
        bus.stall = 0; bus.IM_stall = 0; bus.DM_stall = 0;
        tick();
        idle();
        n_checks++; if (bus.pc !== 32'h300 || bus.rasCount !== 3'd0)
            $display("FAIL stall_release actual=%h/%0d required=%h/0", bus.pc, bus.rasCount, 32'h300);
        else n_pass++;
        bus.stall = 1; bus.mispredict = 1; bus.correctTarget = 32'h700;
        #2;
        rst_n = 0;
        #1;
        n_checks++; if (bus.pc !== 32'h0 || bus.rasCount !== 3'd0)
            $display("FAIL stall_reset actual=%h/%0d required=%h/0", bus.pc, bus.rasCount, 32'h0);
        else n_pass++;
        idle();
        @(negedge clk);
        rst_n = 1;
        tick();
        n_checks++; if (bus.pc !== 32'h4) $display("FAIL post_reset actual=%h required=%h", bus.pc, 32'h4); else n_pass++;
    endtask

    task automatic test_align();
        logic [31:0] exp_pc1, exp_pc2;
        logic        exp_mis;
`ifdef PC_ALIGN_CHK_EN
        exp_pc1 = 32'h300; exp_pc2 = 32'h304; exp_mis = 1'b1;
`else
        exp_pc1 = 32'h302; exp_pc2 = 32'h306; exp_mis = 1'b0;
`endif
        bus.mispredict = 1; bus.correctTarget = 32'h302;
        tick();
        idle();
        n_checks++; if (bus.pc !== exp_pc1 || bus.pcMisaligned !== exp_mis)
            $display("FAIL align_redirect actual=%h/%0b required=%h/%0b", bus.pc, bus.pcMisaligned, exp_pc1, exp_mis);
        else n_pass++;
        bus.stall = 1;
        tick();
        idle();
        n_checks++; if (bus.pc !== exp_pc1 || bus.pcMisaligned !== exp_mis)
            $display("FAIL align_hold actual=%h/%0b required=%h/%0b", bus.pc, bus.pcMisaligned, exp_pc1, exp_mis);
        else n_pass++;
        tick();
        n_checks++; if (bus.pc !== exp_pc2 || bus.pcMisaligned !== 1'b0)
            $display("FAIL align_seq actual=%h/%0b required=%h/0", bus.pc, bus.pcMisaligned, exp_pc2);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_btb();
        test_call_ret();
        test_ras_overflow();
        test_call_and_ret();
        test_stall();
        test_align();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
